vram_port_arbiter: RTL and testbench

//   Shares the single-port video RAM between the display refresh path (cache/row fetch

---
 rtl/vram_port_arbiter.sv | 114 +++++++++++
 tb/tb_vram_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display reads take priority and may lock the RAM for a row burst.
// The paint writer uses idle cycles. Optional fairness slot: define VRAM_ARB_STARVE_GUARD_EN.
module vram_port_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 24,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_DISP_REQ,
    input  logic                  in_DISP_LOCK,
    input  logic [ADDR_WIDTH-1:0] in_DISP_ADDR,
    output logic                  out_DISP_GNT,
    output logic                  out_DISP_RVALID,
    output logic [DATA_WIDTH-1:0] out_DISP_RDATA,
    input  logic                  in_WR_REQ,
    input  logic [ADDR_WIDTH-1:0] in_WR_ADDR,
    input  logic [DATA_WIDTH-1:0] in_WR_DATA,
    output logic                  out_WR_GNT,
    output logic                  out_MEM_EN,
    output logic                  out_MEM_WE,
    output logic [ADDR_WIDTH-1:0] out_MEM_ADDR,
    output logic [DATA_WIDTH-1:0] out_MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] in_MEM_RDATA
);

    typedef enum logic [1:0] {
        ARB,
        DISP_LOCKED,
        SLOT_WR
    } state_t;

    state_t state;
    logic   disp_gnt;
    logic   wr_gnt;
    logic   rd_pipe;
    logic   slot_due;

    assign disp_gnt = in_DISP_REQ && (state != SLOT_WR);
    assign wr_gnt   = in_WR_REQ && (((state == ARB) && !in_DISP_REQ && !in_DISP_LOCK)
                                    || (state == SLOT_WR));

    assign out_DISP_GNT   = disp_gnt;
    assign out_WR_GNT     = wr_gnt;
    assign out_DISP_RDATA = in_MEM_RDATA;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] starve_cnt;

    // Writer blocked by a lock for STARVE_LIMIT cycles gets one stolen slot.
    assign slot_due = (state == DISP_LOCKED) && in_WR_REQ && (starve_cnt == STARVE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if ((state != DISP_LOCKED) || !in_WR_REQ || wr_gnt || slot_due) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_starve_cfg;

    assign slot_due          = 1'b0;
    assign unused_starve_cfg = (STARVE_LIMIT > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            case (state)
                ARB:         if (in_DISP_LOCK) state <= DISP_LOCKED;
                DISP_LOCKED: begin
                    if (slot_due) begin
                        state <= SLOT_WR;
                    end else if (!in_DISP_LOCK) begin
                        state <= ARB;
                    end
                end
                SLOT_WR:     state <= in_DISP_LOCK ? DISP_LOCKED : ARB;
                default:     state <= ARB;
            endcase
        end
    end

    // Address and write data hold their last value on idle cycles; only EN/WE drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_MEM_EN      <= 1'b0;
            out_MEM_WE      <= 1'b0;
            out_MEM_ADDR    <= '0;
            out_MEM_WDATA   <= '0;
            rd_pipe         <= 1'b0;
            out_DISP_RVALID <= 1'b0;
        end else begin
            out_MEM_EN <= disp_gnt || wr_gnt;
            out_MEM_WE <= wr_gnt;
            if (disp_gnt) begin
                out_MEM_ADDR <= in_DISP_ADDR;
            end else if (wr_gnt) begin
                out_MEM_ADDR  <= in_WR_ADDR;
                out_MEM_WDATA <= in_WR_DATA;
            end
            rd_pipe         <= disp_gnt;
            out_DISP_RVALID <= rd_pipe;
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural VRAM model.
// Compile with VRAM_ARB_STARVE_GUARD_EN defined to exercise the fairness slot instead of the long lock.
module tb_vram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_req = 1'b0;
    logic        disp_lock = 1'b0;
    logic [10:0] disp_addr = '0;
    logic        disp_gnt;
    logic        disp_rvalid;
    logic [23:0] disp_rdata;
    logic        wr_req = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        wr_gnt;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    int total = 0;
    int bad = 0;

    vram_port_arbiter #(
        .ADDR_WIDTH  (11),
        .DATA_WIDTH  (24),
        .STARVE_LIMIT(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_DISP_REQ    (disp_req),
        .in_DISP_LOCK   (disp_lock),
        .in_DISP_ADDR   (disp_addr),
        .out_DISP_GNT   (disp_gnt),
        .out_DISP_RVALID(disp_rvalid),
        .out_DISP_RDATA (disp_rdata),
        .in_WR_REQ      (wr_req),
        .in_WR_ADDR     (wr_addr),
        .in_WR_DATA     (wr_data),
        .out_WR_GNT     (wr_gnt),
        .out_MEM_EN     (mem_en),
        .out_MEM_WE     (mem_we),
        .out_MEM_ADDR   (mem_addr),
        .out_MEM_WDATA  (mem_wdata),
        .in_MEM_RDATA   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Initial VRAM contents; address 0x005 holds the known test pixel.
    function automatic logic [23:0] pattern(input logic [10:0] a);
        if (a == 11'h005) return 24'hABCDEF;
        return {2'b10, a, a};
    endfunction

    logic [23:0] ram [0:2047];
    logic        loaded = 1'b0;
    logic [23:0] ram_q = '0;

    assign mem_rdata = ram_q;

    // One-cycle synchronous single-port RAM, preloaded during the first reset.
    always @(posedge clk) begin
        if (rst) begin
            ram_q <= '0;
            if (!loaded) begin
                for (int k = 0; k < 2048; k++) ram[k] <= pattern(11'(k));
                loaded <= 1'b1;
            end
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full read transaction: grant, registered RAM access, data two cycles after grant, single pulse.
    task automatic do_read(input logic [10:0] a, input logic [23:0] exp, input string name);
        @(negedge clk);
        disp_req  = 1'b1;
        disp_addr = a;
        #1;
        check_output({name, "_gnt"}, disp_gnt, 1'b1);
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        check_output({name, "_en"}, mem_en, 1'b1);
        check_output({name, "_we"}, mem_we, 1'b0);
        check_output({name, "_addr"}, mem_addr, a);
        check_output({name, "_rvalid_early"}, disp_rvalid, 1'b0);
        @(negedge clk);
        #1;
        check_output({name, "_rvalid"}, disp_rvalid, 1'b1);
        check_output({name, "_rdata"}, disp_rdata, exp);
        check_output({name, "_en_idle"}, mem_en, 1'b0);
        @(negedge clk);
        #1;
        check_output({name, "_rvalid_pulse"}, disp_rvalid, 1'b0);
    endtask

    typedef struct {
        logic        d;
        logic        l;
        logic        w;
        logic [10:0] addr;
        logic        exp_d;
        logic        exp_w;
    } vec_t;

    vec_t vecs[12];

    task automatic apply_stimulus();
        logic        prev_d = 1'b0;
        logic        prev_w = 1'b0;
        logic [10:0] prev_addr = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            disp_req  = vecs[i].d;
            disp_lock = vecs[i].l;
            wr_req    = vecs[i].w;
            disp_addr = vecs[i].addr;
            wr_addr   = vecs[i].addr;
            wr_data   = 24'hC00000 | 24'(vecs[i].addr);
            #1;
            check_output($sformatf("vec%0d_disp_gnt", i), disp_gnt, vecs[i].exp_d);
            check_output($sformatf("vec%0d_wr_gnt", i), wr_gnt, vecs[i].exp_w);
            check_output($sformatf("vec%0d_mem_en", i), mem_en, prev_d | prev_w);
            check_output($sformatf("vec%0d_mem_we", i), mem_we, prev_w);
            if (prev_d || prev_w)
                check_output($sformatf("vec%0d_mem_addr", i), mem_addr, prev_addr);
            if (prev_w)
                check_output($sformatf("vec%0d_mem_wdata", i), mem_wdata, 24'hC00000 | 24'(prev_addr));
            prev_d    = vecs[i].exp_d;
            prev_w    = vecs[i].exp_w;
            prev_addr = vecs[i].addr;
        end
        disp_req  = 1'b0;
        disp_lock = 1'b0;
        wr_req    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dg;
        int rv;
        int rverr;
        int rd;

        // Test 1: reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_output("rst_mem_en", mem_en, 1'b0);
        check_output("rst_mem_we", mem_we, 1'b0);
        check_output("rst_mem_addr", mem_addr, 11'h0);
        check_output("rst_mem_wdata", mem_wdata, 24'h0);
        check_output("rst_rvalid", disp_rvalid, 1'b0);
        check_output("rst_rdata", disp_rdata, 24'h0);
        check_output("rst_disp_gnt", disp_gnt, 1'b0);
        check_output("rst_wr_gnt", wr_gnt, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_output("idle_mem_en", mem_en, 1'b0);
        check_output("idle_rvalid", disp_rvalid, 1'b0);

        // Test 2: single display read
        do_read(11'h005, 24'hABCDEF, "read5");

        // Test 3: simultaneous requests, display wins, writer follows
        @(negedge clk);
        disp_req  = 1'b1;
        disp_addr = 11'h007;
        wr_req    = 1'b1;
        wr_addr   = 11'h010;
        wr_data   = 24'h123456;
        #1;
        check_output("both_disp_gnt", disp_gnt, 1'b1);
        check_output("both_wr_gnt", wr_gnt, 1'b0);
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        check_output("after_disp_wr_gnt", wr_gnt, 1'b1);
        check_output("after_disp_disp_gnt", disp_gnt, 1'b0);
        check_output("after_disp_mem_addr", mem_addr, 11'h007);
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        check_output("wr_mem_en", mem_en, 1'b1);
        check_output("wr_mem_we", mem_we, 1'b1);
        check_output("wr_mem_addr", mem_addr, 11'h010);
        check_output("wr_mem_wdata", mem_wdata, 24'h123456);
        do_read(11'h010, 24'h123456, "readback10");

        // Table of grant vectors from an idle arbiter
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 11'h200, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 11'h201, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 11'h202, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 11'h203, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 11'h204, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 11'h205, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 11'h206, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 11'h207, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 11'h208, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 11'h209, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 11'h20A, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 11'h20B, 1'b0, 1'b0};
        apply_stimulus();
        @(negedge clk);
        @(negedge clk);

        dg = 0;
        rv = 0;
        rverr = 0;
        rd = 0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        // Test 5: fairness slot during a 40-cycle lock with both requesters busy
        begin
            int werr = 0;
            int derr = 0;
            int wc = 0;
            wr_addr = 11'h300;
            wr_data = 24'h0F0F0F;
            for (int i = 0; i < 45; i++) begin
                logic exp_w;
                logic exp_d;
                @(negedge clk);
                if (i < 40) begin
                    disp_lock = 1'b1;
                    disp_req  = 1'b1;
                    wr_req    = 1'b1;
                    disp_addr = 11'(32'h100 + rd);
                end else begin
                    disp_lock = 1'b0;
                    disp_req  = 1'b0;
                    wr_req    = 1'b0;
                end
                #1;
                exp_w = (i == 17) || (i == 34);
                exp_d = (i < 40) && !exp_w;
                if (wr_gnt !== exp_w) werr++;
                if (disp_gnt !== exp_d) derr++;
                if (wr_gnt) wc++;
                if (disp_gnt) begin dg++; rd++; end
                if (disp_rvalid) begin
                    if (disp_rdata !== pattern(11'(32'h100 + rv))) rverr++;
                    rv++;
                end
            end
            check_output("slot_wr_gnt_pattern_errs", werr, 0);
            check_output("slot_disp_gnt_pattern_errs", derr, 0);
            check_output("slot_wr_gnt_count", wc, 2);
            check_output("slot_disp_gnt_count", dg, 38);
            check_output("slot_rvalid_count", rv, 38);
            check_output("slot_rdata_errs", rverr, 0);
        end
`else
        // Test 4: 64-cycle locked burst starves the writer until the lock has fallen
        begin
            int first_wr = -1;
            int wc = 0;
            wr_req  = 1'b1;
            wr_addr = 11'h300;
            wr_data = 24'h0F0F0F;
            for (int i = 0; i < 70; i++) begin
                @(negedge clk);
                if (i < 64) begin
                    disp_lock = 1'b1;
                    disp_req  = 1'b1;
                    disp_addr = 11'(32'h100 + rd);
                end else begin
                    disp_lock = 1'b0;
                    disp_req  = 1'b0;
                end
                if (first_wr >= 0) wr_req = 1'b0;
                #1;
                if (wr_gnt) begin
                    wc++;
                    if (first_wr < 0) first_wr = i;
                end
                if (disp_gnt) begin dg++; rd++; end
                if (disp_rvalid) begin
                    if (disp_rdata !== pattern(11'(32'h100 + rv))) rverr++;
                    rv++;
                end
            end
            check_output("lock_first_wr_gnt_cycle", first_wr, 65);
            check_output("lock_wr_gnt_count", wc, 1);
            check_output("lock_disp_gnt_count", dg, 64);
            check_output("lock_rvalid_count", rv, 64);
            check_output("lock_rdata_errs", rverr, 0);
        end
`endif
        @(negedge clk);
        @(negedge clk);

        // Test 6: reset right after a locked display grant squashes the read and the lock
        @(negedge clk);
        disp_req  = 1'b1;
        disp_lock = 1'b1;
        disp_addr = 11'h005;
        #1;
        check_output("squash_disp_gnt", disp_gnt, 1'b1);
        @(negedge clk);
        disp_req = 1'b0;
        rst      = 1'b1;
        #1;
        check_output("squash_rvalid_c1", disp_rvalid, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        disp_lock = 1'b0;
        wr_req    = 1'b1;
        wr_addr   = 11'h301;
        wr_data   = 24'h00AA55;
        #1;
        check_output("squash_rvalid_c2", disp_rvalid, 1'b0);
        check_output("post_rst_wr_gnt", wr_gnt, 1'b1);
        check_output("post_rst_mem_en", mem_en, 1'b0);
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        check_output("squash_rvalid_c3", disp_rvalid, 1'b0);
        check_output("post_rst_mem_we", mem_we, 1'b1);
        check_output("post_rst_mem_addr", mem_addr, 11'h301);
        @(negedge clk);
        #1;
        check_output("squash_rvalid_c4", disp_rvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
